spart_host_driver: RTL and testbench

SPART_HOST_DRIVER -- requirements
Module: spart_host_driver

---
 rtl/spart_host_driver.sv | 148 ++++++++++++++
 tb/tb_spart_host_driver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_host_driver.sv
// spart_host_driver: programs the SPART baud divisor, transmits a fixed banner and reads received bytes.
// Define SPART_ECHO_EN to queue received bytes and retransmit them once the banner is done.
module spart_host_driver #(
   parameter int         CLK_HZ     = 100_000_000,
   parameter int         MSG_LEN    = 8,
   parameter logic [7:0] BASE_CHAR  = 8'h41,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] br_cfg,
   input  logic       rda,
   input  logic       tbr,
   output logic       iocs,
   output logic       iorw,
   output logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       cfg_done,
   output logic       ovf
);
   typedef enum logic [2:0] {CFG_LO, CFG_HI, BANNER, GAP, IDLE, RD} state_t;
   localparam logic [15:0] DIV0 = 16'(CLK_HZ / 76800);
   localparam logic [15:0] DIV1 = 16'(CLK_HZ / 153600);
   localparam logic [15:0] DIV2 = 16'(CLK_HZ / 307200);
   localparam logic [15:0] DIV3 = 16'(CLK_HZ / 614400);
   if (MSG_LEN < 1 || MSG_LEN > 255 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("spart_host_driver: MSG_LEN or FIFO_DEPTH out of range");
   end
   state_t      state, ret;
   logic [1:0]  br_q;
   logic [7:0]  idx, wdata, head;
   logic [15:0] div;
   logic        chg, empty;
   assign div = br_q[1] ? (br_q[0] ? DIV3 : DIV2) : (br_q[0] ? DIV1 : DIV0);
   assign chg = br_cfg != br_q;
   assign databus = (iocs && !iorw) ? wdata : 8'bz;
`ifdef SPART_ECHO_EN
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic        push, pop, full, wr;
   assign empty = cnt == '0;
   assign full  = cnt == (AW+1)'(FIFO_DEPTH);
   assign push  = state == RD && !chg;
   assign pop   = state == IDLE && !chg && !rda && tbr && !empty;
   assign wr    = push && (!full || pop);
   assign head  = mem[rp];
   always_ff @(posedge clk)
      if (wr) mem[wp] <= databus;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
         if (push && !wr) ovf <= 1'b1;
      end
`else
   assign empty = 1'b1;
   assign head  = 8'h00;
   assign ovf   = 1'b0;
`endif
   // Bus outputs are registered: each access is visible the cycle after the state that issues it.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state    <= CFG_LO;
         ret      <= IDLE;
         br_q     <= 2'b00;
         idx      <= '0;
         wdata    <= '0;
         iocs     <= 1'b0;
         iorw     <= 1'b1;
         ioaddr   <= 2'b00;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
         cfg_done <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         iocs     <= 1'b0;
         iorw     <= 1'b1;
         if (chg) begin
            br_q     <= br_cfg;
            cfg_done <= 1'b0;
            idx      <= '0;
            state    <= CFG_LO;
         end else begin
            case (state)
               CFG_LO: begin
                  iocs   <= 1'b1;
                  iorw   <= 1'b0;
                  ioaddr <= 2'b10;
                  wdata  <= div[7:0];
                  state  <= CFG_HI;
               end
               CFG_HI: begin
                  iocs     <= 1'b1;
                  iorw     <= 1'b0;
                  ioaddr   <= 2'b11;
                  wdata    <= div[15:8];
                  cfg_done <= 1'b1;
                  state    <= BANNER;
               end
               BANNER:
                  if (rda) begin
                     iocs   <= 1'b1;
                     ioaddr <= 2'b00;
                     ret    <= BANNER;
                     state  <= RD;
                  end else if (tbr) begin
                     iocs   <= 1'b1;
                     iorw   <= 1'b0;
                     ioaddr <= 2'b00;
                     wdata  <= BASE_CHAR + idx;
                     idx    <= idx + 8'd1;
                     state  <= GAP;
                  end
               GAP: state <= idx == 8'(MSG_LEN) ? IDLE : BANNER;
               IDLE:
                  if (rda) begin
                     iocs   <= 1'b1;
                     ioaddr <= 2'b00;
                     ret    <= IDLE;
                     state  <= RD;
                  end else if (tbr && !empty) begin
                     iocs   <= 1'b1;
                     iorw   <= 1'b0;
                     ioaddr <= 2'b00;
                     wdata  <= head;
                     state  <= GAP;
                  end
               RD: begin
                  rx_byte  <= databus;
                  rx_valid <= 1'b1;
                  state    <= ret;
               end
               default: state <= CFG_LO;
            endcase
         end
      end
endmodule

// File: tb/tb_spart_host_driver.sv
// tb_spart_host_driver: table-driven and randomized checks of spart_host_driver against a SPART bus model.
module tb_spart_host_driver;
   typedef struct {logic rd; logic [1:0] a; logic [7:0] d; int cyc;} acc_t;
   typedef struct {logic [1:0] br; logic [15:0] div;} vec_t;
   logic clk = 0, rst = 0, rda = 0, tbr = 0;
   logic [1:0] br_cfg = 2'b00;
   logic iocs, iorw, cfg_done, ovf, rx_valid;
   logic [1:0] ioaddr;
   logic [7:0] rx_byte;
   logic [7:0] rx_cur = 8'h00;
   wire  [7:0] databus;
   acc_t acc_log[$];
   logic [7:0] rxv[$];
   logic [7:0] send [1024];
   int n_send = 0, n_read = 0, cyc = 0, n_vec = 0, n_err = 0;
   int bad_addr = 0, bad_rw = 0, gap_err = 0, rxv_long = 0;
   logic pend = 0, prev_tx = 0, prev_rxv = 0;

   always #5 clk = ~clk;
   assign databus = (iocs && iorw) ? rx_cur : 8'bz;

   spart_host_driver dut (
      .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
      .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
      .rx_byte(rx_byte), .rx_valid(rx_valid), .cfg_done(cfg_done), .ovf(ovf)
   );

   // SPART side: logs every access, serves reads from send[], raises rda while bytes are pending
   always @(negedge clk) begin
      cyc++;
      if (pend) begin
         n_read++;
         pend = 0;
      end
      if (rst) begin
         if (iocs && ioaddr == 2'b01) bad_addr++;
         if (!iocs && !iorw) bad_rw++;
         if (iocs && prev_tx) gap_err++;
         if (rx_valid && prev_rxv) rxv_long++;
         if (iocs) acc_log.push_back('{iorw, ioaddr, databus, cyc});
         if (iocs && iorw) pend = 1;
         if (rx_valid) rxv.push_back(rx_byte);
      end
      prev_tx  = rst && iocs && !iorw && ioaddr == 2'b00;
      prev_rxv = rst && rx_valid;
      rx_cur   = send[n_read];
      rda      = !pend && n_read < n_send;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [10:0] acc_at(input int i);
      return i < acc_log.size() ? {acc_log[i].rd, acc_log[i].a, acc_log[i].d} : 11'h7ff;
   endfunction

   task automatic wait_acc(input int base, input int n, input int lim, input string nm);
      int k;
      k = 0;
      while (acc_log.size() - base < n && k < lim) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk(nm, 32'(acc_log.size() - base >= n), 1);
   endtask

   task automatic do_reset(input logic [1:0] br);
      rst = 0;
      br_cfg = br;
      tbr = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl [4];
      int b, r0, k;
      logic [7:0] e;
      tbl = '{'{2'b00, 16'd1302}, '{2'b01, 16'd651}, '{2'b10, 16'd325}, '{2'b11, 16'd162}};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_iocs", iocs, 0);
      chk("rst_iorw", iorw, 1);
      chk("rst_ioaddr", ioaddr, 0);
      chk("rst_rx_byte", rx_byte, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_cfg_done", cfg_done, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_databus_z", 32'(databus === 8'bz), 1);
      rst = 1;

      // divisor programming for every baud setting
      foreach (tbl[i]) begin
         do_reset(tbl[i].br);
         b = acc_log.size();
         wait_acc(b, 2, 20, "cfg_wait");
         chk("cfg_lo", acc_at(b), {3'b010, tbl[i].div[7:0]});
         chk("cfg_hi", acc_at(b + 1), {3'b011, tbl[i].div[15:8]});
         if (acc_log.size() - b >= 2) chk("cfg_consecutive", acc_log[b + 1].cyc - acc_log[b].cyc, 1);
         @(posedge clk);
         #1 chk("cfg_done_set", cfg_done, 1);
      end

      // banner with tbr held high
      do_reset(2'b01);
      b = acc_log.size();
      tbr = 1;
      repeat (60) @(posedge clk);
      #1;
      chk("banner_count", acc_log.size() - b, 10);
      for (int j = 0; j < 8; j++) begin
         e = 8'h41 + 8'(j);
         chk($sformatf("banner_%0d", j), acc_at(b + 2 + j), {3'b000, e});
         if (j > 0 && b + 2 + j < acc_log.size())
            chk("banner_spacing", acc_log[b + 2 + j].cyc - acc_log[b + 1 + j].cyc, 2);
      end

      // receive during banner
      do_reset(2'b01);
      b = acc_log.size();
      r0 = rxv.size();
      tbr = 1;
      wait_acc(b, 5, 40, "rx_wait");
      send[n_send] = 8'h5A;
      n_send++;
      repeat (40) @(posedge clk);
      #1;
      chk("rx_read_first", acc_at(b + 5), {3'b100, 8'h5A});
      chk("rx_then_tx", acc_at(b + 6), {3'b000, 8'h44});
      chk("rx_byte", rx_byte, 8'h5A);
      chk("rx_pulses", rxv.size() - r0, 1);
      chk("rx_pulse_data", rxv.size() > r0 ? rxv[r0] : 8'h00, 8'h5A);

      // baud change from IDLE reprograms and replays the banner
      chk("cfg_before_change", cfg_done, 1);
      b = acc_log.size();
      br_cfg = 2'b11;
      @(posedge clk);
      #1 chk("cfg_drop", cfg_done, 0);
      wait_acc(b, 10, 60, "rebanner_wait");
      chk("recfg_lo", acc_at(b), {3'b010, 8'hA2});
      chk("recfg_hi", acc_at(b + 1), {3'b011, 8'h00});
      chk("rebanner_first", acc_at(b + 2), {3'b000, 8'h41});
      chk("rebanner_last", acc_at(b + 9), {3'b000, 8'h48});

      // reset asserted in the middle of a banner write
      do_reset(2'b01);
      b = acc_log.size();
      tbr = 1;
      wait_acc(b, 5, 40, "midrst_wait");
      k = 0;
      while (!iocs && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("midrst_in_write", iocs, 1);
      rst = 0;
      #1;
      chk("midrst_iocs", iocs, 0);
      chk("midrst_iorw", iorw, 1);
      chk("midrst_ioaddr", ioaddr, 0);
      chk("midrst_cfg_done", cfg_done, 0);
      chk("midrst_databus_z", 32'(databus === 8'bz), 1);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      b = acc_log.size();
      wait_acc(b, 2, 20, "midrst_cfg_wait");
      chk("midrst_restart_lo", acc_at(b), {3'b010, 8'h8B});
      chk("midrst_restart_hi", acc_at(b + 1), {3'b011, 8'h02});

      // five bytes received while tbr is low
      do_reset(2'b01);
      tbr = 1;
      repeat (40) @(posedge clk);
      #1 tbr = 0;
      r0 = n_send;
      for (int j = 0; j < 5; j++) begin
         send[n_send] = 8'($urandom);
         n_send++;
      end
      repeat (40) @(posedge clk);
      #1;
      chk("echo_reads", n_read - r0, 5);
`ifdef SPART_ECHO_EN
      chk("ovf_set", ovf, 1);
`else
      chk("ovf_tied", ovf, 0);
`endif
      b = acc_log.size();
      tbr = 1;
      repeat (40) @(posedge clk);
      #1;
`ifdef SPART_ECHO_EN
      chk("echo_count", acc_log.size() - b, 4);
      for (int j = 0; j < 4; j++) chk("echo_data", acc_at(b + j), {3'b000, send[r0 + j]});
      chk("ovf_sticky", ovf, 1);
`else
      chk("no_echo", acc_log.size() - b, 0);
`endif

      // randomized traffic against a transaction-level model
      for (int t = 0; t < 3; t++) begin
         logic [1:0] br;
         logic [31:0] dv;
         logic [7:0] mq[$];
         logic ovf_m;
         int bi, ri, s0, rv0, n_extra;
         br = 2'($urandom);
         do_reset(br);
         b = acc_log.size();
         s0 = n_send;
         rv0 = rxv.size();
         for (int c = 0; c < 500; c++) begin
            tbr = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 9) == 0 && n_send - n_read < 3 && n_send < 1000) begin
               send[n_send] = 8'($urandom);
               n_send++;
            end
            @(posedge clk);
            #1;
         end
         tbr = 1;
         repeat (100) @(posedge clk);
         #1;
         chk("rnd_all_read", n_read, n_send);
         dv = 100_000_000 / (16 * (4800 << br));
         chk("rnd_cfg_lo", acc_at(b), {3'b010, dv[7:0]});
         chk("rnd_cfg_hi", acc_at(b + 1), {3'b011, dv[15:8]});
         mq.delete();
         ovf_m = 0;
         bi = 0;
         ri = s0;
         n_extra = 0;
         for (int i = b + 2; i < acc_log.size(); i++) begin
            if (acc_log[i].rd) begin
               chk("rnd_rd", {acc_log[i].a, acc_log[i].d}, {2'b00, send[ri]});
               ri++;
               if (mq.size() < 4) mq.push_back(acc_log[i].d);
               else ovf_m = 1;
            end else if (acc_log[i].a != 2'b00) begin
               n_extra++;
            end else if (bi < 8) begin
               e = 8'h41 + 8'(bi);
               chk("rnd_banner", acc_log[i].d, e);
               bi++;
            end else begin
`ifdef SPART_ECHO_EN
               if (mq.size() != 0) chk("rnd_echo", acc_log[i].d, mq.pop_front());
               else n_extra++;
`else
               n_extra++;
`endif
            end
         end
         chk("rnd_banner_done", bi, 8);
         chk("rnd_unexpected_writes", n_extra, 0);
         chk("rnd_rx_pulses", rxv.size() - rv0, n_send - s0);
         for (int j = 0; j < n_send - s0 && rv0 + j < rxv.size(); j++)
            chk("rnd_rx_byte", rxv[rv0 + j], send[s0 + j]);
`ifdef SPART_ECHO_EN
         chk("rnd_ovf", ovf, ovf_m);
         chk("rnd_drained", mq.size(), 0);
`else
         chk("rnd_ovf", ovf, 0);
`endif
      end

      chk("bus_no_status", bad_addr, 0);
      chk("bus_idle_iorw", bad_rw, 0);
      chk("bus_tx_gap", gap_err, 0);
      chk("rx_valid_width", rxv_long, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
